// File: rtl/mcu_spi_pkg.sv
// mcu_spi_pkg: shared target ids and framing states for the MCU SPI link
package mcu_spi_pkg;
    localparam logic [7:0] TGT_SYS = 8'd1;
    localparam logic [7:0] TGT_HID = 8'd2;
    localparam logic [7:0] TGT_OSD = 8'd3;
    typedef enum logic [2:0] {WAIT_IDLE, IDLE, TARGET, COMMAND, PAYLOAD} state_t;
endpackage

// File: rtl/spi_sync.sv
// spi_sync: multi-flop synchroniser with registered previous value for edge pulses
module spi_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);
    logic [STAGES-1:0] sr;
    logic prev;
    always_ff @(posedge clk) begin
        if (reset) begin
            sr   <= '0;
            prev <= 1'b0;
        end else begin
            sr   <= {sr[STAGES-2:0], d};
            prev <= sr[STAGES-1];
        end
    end
    assign q    = sr[STAGES-1];
    assign rise = q & ~prev;
    assign fall = ~q & prev;
endmodule

// File: rtl/mcu_spi_rx.sv
// mcu_spi_rx: SPI mode-0 target framing target/command/payload bytes into per-target strobes
module mcu_spi_rx
    import mcu_spi_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] ID_BYTE     = 8'h5C
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       spi_csn,
    input  logic       spi_sck,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic [7:0] data_out,
    output logic       data_start,
    output logic       sys_strobe,
    output logic       hid_strobe,
    output logic       osd_strobe,
    input  logic [7:0] sys_din,
    input  logic [7:0] hid_din
);
    logic csn_n, csn_rise, csn_fall, sck_rise, sck_fall, mosi;
    logic sck_lvl_unused, mosi_rise_unused, mosi_fall_unused;
    logic [7:0] rx_shift, tx_shift, tgt, sel, ret_byte;
    logic [2:0] bit_cnt;
    logic byte_done, active, emit, known, bit_edge;
    state_t state, state_nx;

    spi_sync #(.STAGES(SYNC_STAGES)) u_csn (
        .clk(clk), .reset(reset), .d(spi_csn), .q(csn_n), .rise(csn_rise), .fall(csn_fall)
    );
    spi_sync #(.STAGES(SYNC_STAGES)) u_sck (
        .clk(clk), .reset(reset), .d(spi_sck), .q(sck_lvl_unused), .rise(sck_rise), .fall(sck_fall)
    );
    spi_sync #(.STAGES(SYNC_STAGES)) u_mosi (
        .clk(clk), .reset(reset), .d(spi_mosi), .q(mosi), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );

    assign bit_edge = sck_rise && !csn_n;
    assign active   = state inside {TARGET, COMMAND, PAYLOAD};
    assign emit     = byte_done && (state == COMMAND || state == PAYLOAD);
    assign known    = tgt == TGT_SYS || tgt == TGT_HID || tgt == TGT_OSD;
    // the target byte selects its own return byte before tgt is latched
    assign sel      = state == TARGET ? rx_shift : tgt;
    assign ret_byte = sel == TGT_SYS ? sys_din : sel == TGT_HID ? hid_din : 8'h00;
    assign spi_miso = tx_shift[7];

    always_ff @(posedge clk) begin
        if (reset) state <= WAIT_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (state == WAIT_IDLE)      state_nx = csn_n ? IDLE : WAIT_IDLE;
        else if (state == IDLE)      state_nx = csn_fall ? TARGET : IDLE;
        else if (csn_rise)           state_nx = IDLE;
        else if (byte_done)          state_nx = state == TARGET ? COMMAND : PAYLOAD;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt    <= '0;
            byte_done  <= 1'b0;
            rx_shift   <= '0;
            tx_shift   <= '0;
            tgt        <= '0;
            data_out   <= '0;
            data_start <= 1'b0;
            sys_strobe <= 1'b0;
            hid_strobe <= 1'b0;
            osd_strobe <= 1'b0;
        end else begin
            byte_done <= bit_edge && bit_cnt == 3'd7;
            if (csn_rise || csn_fall) bit_cnt <= '0;
            else if (bit_edge)        bit_cnt <= bit_cnt + 3'd1;
            if (bit_edge) rx_shift <= {rx_shift[6:0], mosi};
            if (state == TARGET && byte_done) tgt <= rx_shift;
            if (state == IDLE && csn_fall)                   tx_shift <= ID_BYTE;
            else if (byte_done && active)                    tx_shift <= ret_byte;
            else if (sck_fall && !csn_n && bit_cnt != 3'd0)  tx_shift <= {tx_shift[6:0], 1'b0};
            sys_strobe <= emit && tgt == TGT_SYS;
            hid_strobe <= emit && tgt == TGT_HID;
            osd_strobe <= emit && tgt == TGT_OSD;
            data_start <= emit && known && state == COMMAND;
            if (emit && known) data_out <= rx_shift;
        end
    end
endmodule

// File: tb/tb_mcu_spi_rx.sv
// tb_mcu_spi_rx: directed SPI frames with a strobe scoreboard and miso checks
module tb_mcu_spi_rx;
    logic clk = 1'b0, reset = 1'b1;
    logic spi_csn = 1'b1, spi_sck = 1'b0, spi_mosi = 1'b0;
    logic spi_miso, data_start, sys_strobe, hid_strobe, osd_strobe;
    logic [7:0] data_out;
    logic [7:0] sys_din = 8'h3C, hid_din = 8'h77;

    typedef struct packed {logic [1:0] id; logic [7:0] data; logic start;} exp_t;
    exp_t exp_q[$];
    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    int checks = 0, failures = 0;
    logic prev_any = 1'b0;

    mcu_spi_rx dut (
        .clk(clk), .reset(reset), .spi_csn(spi_csn), .spi_sck(spi_sck), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .data_out(data_out), .data_start(data_start),
        .sys_strobe(sys_strobe), .hid_strobe(hid_strobe), .osd_strobe(osd_strobe),
        .sys_din(sys_din), .hid_din(hid_din)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic expect_strobe(input logic [1:0] id, input logic [7:0] d, input logic s);
        exp_q.push_back({id, d, s});
    endtask

    // scoreboard monitor: every strobe must match the oldest expected byte
    always @(negedge clk) begin : monitor
        logic any;
        exp_t e;
        any = sys_strobe | hid_strobe | osd_strobe;
        if (!reset && any) begin
            check("strobe_onehot", 32'($countones({sys_strobe, hid_strobe, osd_strobe})), 1);
            check("strobe_width", 32'(prev_any), 0);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_strobe actual=%b%b%b data=%0h expected=none",
                         sys_strobe, hid_strobe, osd_strobe, data_out);
            end else begin
                e = exp_q.pop_front();
                check("strobe_target", 32'(osd_strobe ? 2'd3 : hid_strobe ? 2'd2 : 2'd1), 32'(e.id));
                check("strobe_data", 32'(data_out), 32'(e.data));
                check("strobe_start", 32'(data_start), 32'(e.start));
            end
        end
        prev_any = any && !reset;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic spi_bits(input logic [7:0] b, input int n, input int half, output logic [7:0] m);
        m = 8'h00;
        for (int i = 0; i < n; i++) begin
            spi_mosi = b[7-i];
            tick(half);
            m = {m[6:0], spi_miso};
            spi_sck = 1'b1;
            tick(half);
            spi_sck = 1'b0;
        end
    endtask

    task automatic frame(input int half);
        logic [7:0] m;
        rx_q = {};
        spi_csn = 1'b0;
        tick(8);
        foreach (tx_q[i]) begin
            spi_bits(tx_q[i], 8, half, m);
            rx_q.push_back(m);
        end
        tick(half);
        spi_csn = 1'b1;
        tick(12);
    endtask

    task automatic check_cleared(input string name);
        check({name, "_data_out"}, 32'(data_out), 0);
        check({name, "_strobes"}, 32'({sys_strobe, hid_strobe, osd_strobe, data_start}), 0);
        check({name, "_miso"}, 32'(spi_miso), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] m;
        tick(4);
        check_cleared("reset");
        reset = 1'b0;
        tick(10);

        // OSD frame, command then two payload bytes; OSD returns zeros
        expect_strobe(2'd3, 8'h02, 1'b1);
        expect_strobe(2'd3, 8'h05, 1'b0);
        expect_strobe(2'd3, 8'hA5, 1'b0);
        tx_q = {8'h03, 8'h02, 8'h05, 8'hA5};
        frame(4);
        check("osd_miso_id", 32'(rx_q[0]), 32'h5C);
        check("osd_miso_b1", 32'(rx_q[1]), 0);
        check("osd_miso_b3", 32'(rx_q[3]), 0);

        // SYS frame returns sys_din after the ID byte
        expect_strobe(2'd1, 8'h10, 1'b1);
        tx_q = {8'h01, 8'h10};
        frame(4);
        check("sys_miso_id", 32'(rx_q[0]), 32'h5C);
        check("sys_miso_ret", 32'(rx_q[1]), 32'h3C);

        // HID frame returns hid_din
        expect_strobe(2'd2, 8'hC3, 1'b1);
        expect_strobe(2'd2, 8'h00, 1'b0);
        tx_q = {8'h02, 8'hC3, 8'h00};
        frame(4);
        check("hid_miso_ret", 32'(rx_q[1]), 32'h77);

        // csn released after 5 payload bits: partial byte dropped
        expect_strobe(2'd3, 8'h01, 1'b1);
        spi_csn = 1'b0;
        tick(8);
        spi_bits(8'h03, 8, 4, m);
        spi_bits(8'h01, 8, 4, m);
        spi_bits(8'hFF, 5, 4, m);
        tick(4);
        spi_csn = 1'b1;
        tick(12);
        expect_strobe(2'd3, 8'h01, 1'b1);
        expect_strobe(2'd3, 8'h01, 1'b0);
        tx_q = {8'h03, 8'h01, 8'h01};
        frame(4);

        // reset mid-payload: rest of the frame must be ignored
        expect_strobe(2'd3, 8'h01, 1'b1);
        spi_csn = 1'b0;
        tick(8);
        spi_bits(8'h03, 8, 4, m);
        spi_bits(8'h01, 8, 4, m);
        spi_bits(8'hE0, 3, 4, m);
        reset = 1'b1;
        tick(2);
        check_cleared("midreset");
        reset = 1'b0;
        spi_bits(8'h00, 5, 4, m);
        spi_bits(8'h03, 8, 4, m);
        spi_bits(8'h01, 8, 4, m);
        spi_bits(8'h5A, 8, 4, m);
        tick(4);
        spi_csn = 1'b1;
        tick(12);
        expect_strobe(2'd2, 8'h33, 1'b1);
        expect_strobe(2'd2, 8'h44, 1'b0);
        tx_q = {8'h02, 8'h33, 8'h44};
        frame(4);

        // unknown target: no strobes, miso zero after ID
        tx_q = {8'h07, 8'h11, 8'h22, 8'h33, 8'h44};
        frame(4);
        check("unk_miso_id", 32'(rx_q[0]), 32'h5C);
        check("unk_miso_b1", 32'(rx_q[1]), 0);
        check("unk_miso_b4", 32'(rx_q[4]), 0);

        // fast sck = clk/4, 64 bytes after the target byte
        tx_q = {8'h03};
        for (int i = 0; i < 64; i++) begin
            logic [7:0] b;
            b = 8'(i * 37 + 5);
            expect_strobe(2'd3, b, i == 0);
            tx_q.push_back(b);
        end
        frame(2);

        tick(30);
        check("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
